// File: rtl/dsp_mult_q.sv
// rtl/dsp_mult_q.sv - pipelined fixed-point multiplier with stream join and scaled output
//
// Purpose:
//   Four-stage multiplier for Q-format datapaths (mixers, gain stages). Operands A and
//   B arrive on two ready/valid streams and are joined, so both are consumed together
//   or not at all. The full-width product is shifted right by SHIFT. It is optionally
//   rounded half-up, and saturated or wrapped to OUTPUT_WIDTH. A one-bit overflow flag
//   travels with each result. The multiply is kept in its own register stage (S1 -> S2)
//   so that it maps onto a DSP slice with input and product registers.
//
// Ports:
//   clk             clock
//   rst             synchronous reset, active high
//   input_a_tdata   operand A (A_WIDTH)
//   input_a_tvalid  operand A valid
//   input_a_tready  operand A ready (only when B is also valid and the pipe can move)
//   input_b_tdata   operand B (B_WIDTH)
//   input_b_tvalid  operand B valid
//   input_b_tready  operand B ready (only when A is also valid and the pipe can move)
//   output_tdata    scaled product (OUTPUT_WIDTH)
//   output_tvalid   result valid
//   output_tready   downstream ready
//   output_tuser    overflow flag: the result was clamped (SATURATE=1) or wrapped (SATURATE=0)

module dsp_mult_q #(
  parameter int A_WIDTH      = 16,
  parameter int B_WIDTH      = 16,
  parameter int OUTPUT_WIDTH = 16,
  parameter int SHIFT        = 15,
  parameter bit SIGNED       = 1'b1,
  parameter bit ROUND        = 1'b1,
  parameter bit SATURATE     = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [A_WIDTH-1:0]      input_a_tdata,
  input  logic                    input_a_tvalid,
  output logic                    input_a_tready,
  input  logic [B_WIDTH-1:0]      input_b_tdata,
  input  logic                    input_b_tvalid,
  output logic                    input_b_tready,
  output logic [OUTPUT_WIDTH-1:0] output_tdata,
  output logic                    output_tvalid,
  input  logic                    output_tready,
  output logic                    output_tuser
);

  // Full product width, and the output width under a shorter name.
  localparam int PW = A_WIDTH + B_WIDTH;
  localparam int W  = OUTPUT_WIDTH;

  // The rounding constant is 2^(SHIFT-1). It exists only when rounding is enabled and
  // there is something to shift away. RSH is clamped so that the expression stays legal
  // when SHIFT=0.
  localparam int          RSH     = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [PW:0] ONE     = {{PW{1'b0}}, 1'b1};
  localparam logic [PW:0] RND_ADD = (ROUND && (SHIFT > 0)) ? (ONE << RSH) : {(PW+1){1'b0}};

  // Pipeline registers.
  logic [A_WIDTH-1:0] a0, a1;
  logic [B_WIDTH-1:0] b0, b1;
  logic [PW-1:0]      p2;
  logic               v0, v1, v2, v3;
  logic [W-1:0]       out_q;
  logic               user_q;

  // Handshake.
  logic en;
  logic accept;

  // Datapath intermediates.
  logic [PW-1:0] a_ext;
  logic [PW-1:0] b_ext;
  logic [PW-1:0] product;
  logic [PW:0]   p_ext;
  logic [PW:0]   r_sum;
  logic [PW:0]   q_shift;
  logic          ovf;
  logic [W-1:0]  lim_max;
  logic [W-1:0]  lim_min;
  logic [W-1:0]  result;

  // -------------------------------------------------------------------------
  // Flow control
  // -------------------------------------------------------------------------
  // The whole pipe moves as one unit. It stalls only when the output register holds
  // a result that the consumer is not taking. Bubbles advance too, so a stalled output
  // is filled by the sample behind it only when that output drains.
  assign en     = ~v3 | output_tready;
  assign accept = input_a_tvalid & input_b_tvalid & en;

  // Each side is ready only when the other side is presenting data. This way neither
  // operand is consumed without its partner.
  assign input_a_tready = input_b_tvalid & en;
  assign input_b_tready = input_a_tvalid & en;

  // -------------------------------------------------------------------------
  // S1 -> S2 multiply
  // -------------------------------------------------------------------------
  // Both operands are extended to the full product width and multiplied modulo 2^PW.
  // In two's complement the low PW bits of that product equal the exact signed
  // product, so a single unsigned multiplier serves both SIGNED settings.
  always_comb begin
    a_ext = {PW{1'b0}};
    b_ext = {PW{1'b0}};
    if (SIGNED) begin
      a_ext = PW'($signed(a1));
      b_ext = PW'($signed(b1));
    end else begin
      a_ext = PW'(a1);
      b_ext = PW'(b1);
    end
    product = a_ext * b_ext;
  end

  // -------------------------------------------------------------------------
  // S2 -> S3 scale, round, range check
  // -------------------------------------------------------------------------
  always_comb begin
    p_ext   = {(PW+1){1'b0}};
    r_sum   = {(PW+1){1'b0}};
    q_shift = {(PW+1){1'b0}};
    ovf     = 1'b0;
    lim_max = {W{1'b1}};
    lim_min = {W{1'b0}};
    result  = {W{1'b0}};

    // Add one guard bit so that the rounding add cannot carry out of the word.
    if (SIGNED) begin
      p_ext = {p2[PW-1], p2};
    end else begin
      p_ext = {1'b0, p2};
    end
    r_sum = p_ext + RND_ADD;

    // Arithmetic shift gives floor division for negative values, which makes the
    // rounding bias above "round half up" rather than "round half away from zero".
    if (SIGNED) begin
      q_shift = $signed(r_sum) >>> SHIFT;
    end else begin
      q_shift = r_sum >> SHIFT;
    end

    // Range check. A signed value fits in W bits when every bit from the W-1 sign bit
    // up to the top is a copy of that sign. An unsigned value fits when nothing above
    // bit W-1 is set.
    if (SIGNED) begin
      ovf = ~((&q_shift[PW:W-1]) | ~(|q_shift[PW:W-1]));
    end else begin
      ovf = |q_shift[PW:W];
    end

    // Clamp limits: signed uses 0111..1 / 1000..0, unsigned uses all ones / zero.
    if (SIGNED) begin
      lim_max[W-1] = 1'b0;
      lim_min[W-1] = 1'b1;
    end

    if (ovf && SATURATE) begin
      if (SIGNED && q_shift[PW]) begin
        result = lim_min;
      end else begin
        result = lim_max;
      end
    end else begin
      // Wrap mode, or in range: keep the low bits.
      result = q_shift[W-1:0];
    end
  end

  // -------------------------------------------------------------------------
  // Pipeline registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      a0     <= '0;
      b0     <= '0;
      a1     <= '0;
      b1     <= '0;
      p2     <= '0;
      out_q  <= '0;
      user_q <= 1'b0;
      v0     <= 1'b0;
      v1     <= 1'b0;
      v2     <= 1'b0;
      v3     <= 1'b0;
    end else if (en) begin
      // S0: operand capture
      a0     <= input_a_tdata;
      b0     <= input_b_tdata;
      v0     <= accept;
      // S1: operand pipe register (DSP A/B register)
      a1     <= a0;
      b1     <= b0;
      v1     <= v0;
      // S2: full product (DSP M register)
      p2     <= product;
      v2     <= v1;
      // S3: scaled result, which is the output register
      out_q  <= result;
      user_q <= ovf;
      v3     <= v2;
    end
  end

  assign output_tdata  = out_q;
  assign output_tuser  = user_q;
  assign output_tvalid = v3;

endmodule

// File: tb/tb_dsp_mult_q.sv
// tb/tb_dsp_mult_q.sv - self-checking bench for dsp_mult_q
//
// Purpose:
//   Two instances share the same input streams. u_main uses the default parameters
//   (round and saturate). u_alt truncates and wraps. Expected results come from plain
//   integer arithmetic on the operands and are queued in acceptance order.

module tb_dsp_mult_q;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a_data, b_data;
  logic        a_valid, b_valid, out_ready;
  logic        a_ready, b_ready, a_ready2, b_ready2;
  logic [15:0] m_data, x_data;
  logic        m_valid, x_valid, m_user, x_user;

  always #5 clk = ~clk;

  dsp_mult_q u_main (
    .clk(clk), .rst(rst),
    .input_a_tdata(a_data), .input_a_tvalid(a_valid), .input_a_tready(a_ready),
    .input_b_tdata(b_data), .input_b_tvalid(b_valid), .input_b_tready(b_ready),
    .output_tdata(m_data), .output_tvalid(m_valid), .output_tready(out_ready),
    .output_tuser(m_user)
  );

  dsp_mult_q #(.ROUND(1'b0), .SATURATE(1'b0)) u_alt (
    .clk(clk), .rst(rst),
    .input_a_tdata(a_data), .input_a_tvalid(a_valid), .input_a_tready(a_ready2),
    .input_b_tdata(b_data), .input_b_tvalid(b_valid), .input_b_tready(b_ready2),
    .output_tdata(x_data), .output_tvalid(x_valid), .output_tready(out_ready),
    .output_tuser(x_user)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [33:0] exp_q[$];
  int          n_acc = 0;
  int          n_out = 0;
  bit          last_acc;
  bit          last_a_ready;
  bit          last_m_valid;
  logic [15:0] last_m_data, last_x_data;
  bit          last_m_user, last_x_user;
  bit          prev_stall = 1'b0;
  logic [15:0] prev_data;
  bit          prev_user;

  // Q1.15 x Q1.15 -> Q1.15 reference, computed with wide integers. Returns {overflow, data}.
  function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input bit rnd, input bit sat);
    longint      p, q;
    logic [15:0] d;
    bit          ov;
    p = longint'($signed(a)) * longint'($signed(b));
    if (rnd) p = p + 64'sd16384;
    q = p >>> 15;
    ov = (q > 64'sd32767) || (q < -64'sd32768);
    if (ov && sat) d = (q > 0) ? 16'h7fff : 16'h8000;
    else           d = q[15:0];
    return {ov, d};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle. Handshakes are sampled at the falling edge, the scoreboard is
  // updated, and the task returns 1 time unit after the rising edge, ready for new drive.
  task automatic tick();
    logic [33:0] e;
    @(negedge clk);
    last_acc     = a_valid & b_valid & a_ready & b_ready & a_ready2 & b_ready2 & ~rst;
    last_a_ready = a_ready;
    last_m_valid = m_valid;
    last_m_data  = m_data;
    last_m_user  = m_user;
    last_x_data  = x_data;
    last_x_user  = x_user;
    if (last_acc) begin
      exp_q.push_back({model(a_data, b_data, 1'b1, 1'b1), model(a_data, b_data, 1'b0, 1'b0)});
      n_acc++;
    end
    if (prev_stall) begin
      chk("hold_data", m_data, prev_data);
      chk("hold_user", m_user, prev_user);
    end
    prev_stall = m_valid & ~out_ready & ~rst;
    prev_data  = m_data;
    prev_user  = m_user;
    if (m_valid && out_ready && !rst) begin
      n_out++;
      chk("out_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("main_data", m_data, e[32:17]);
        chk("main_user", m_user, e[33]);
        chk("alt_valid", x_valid, 1);
        chk("alt_data", x_data, e[15:0]);
        chk("alt_user", x_user, e[16]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    a_valid = 0; b_valid = 0; out_ready = 1;
    for (int k = 0; k < 12; k++) tick();
    chk("drain_empty", exp_q.size(), 0);
  endtask

  // A single sample through an empty pipe, with latency and spec-constant checks.
  task automatic run_one(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] em, input bit um, input logic [15:0] ex, input bit ux);
    a_data = a; b_data = b; a_valid = 1; b_valid = 1; out_ready = 1;
    tick();
    chk({tag, "_accept"}, last_acc, 1);
    a_valid = 0; b_valid = 0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k < 4) chk({tag, "_early_valid"}, last_m_valid, 0);
    end
    chk({tag, "_valid_at_4"}, last_m_valid, 1);
    chk({tag, "_main_data"}, last_m_data, em);
    chk({tag, "_main_user"}, last_m_user, um);
    chk({tag, "_alt_data"}, last_x_data, ex);
    chk({tag, "_alt_user"}, last_x_user, ux);
    drain();
  endtask

  initial begin
    logic [15:0] sa[8], sb[8];
    int          idx, acc0, out0;

    // Reset state
    rst = 1; a_valid = 0; b_valid = 0; out_ready = 0; a_data = 0; b_data = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_user", m_user, 0);
    chk("rst_alt_data", x_data, 0);
    chk("rst_a_ready", a_ready, 0);
    rst = 0;

    // Directed arithmetic cases
    run_one("half_sq", 16'h4000, 16'h4000, 16'h2000, 0, 16'h2000, 0);
    run_one("neg_one_sq", 16'h8000, 16'h8000, 16'h7fff, 1, 16'h8000, 1);
    run_one("round_up", 16'h0001, 16'h4000, 16'h0001, 0, 16'h0000, 0);
    run_one("round_neg", 16'hffff, 16'h0001, 16'h0000, 0, 16'hffff, 0);

    // Backpressure: the pipe holds four samples, then both readies drop
    for (int i = 0; i < 8; i++) begin
      sa[i] = 16'($urandom);
      sb[i] = 16'($urandom);
    end
    sa[2] = 16'h8000; sb[2] = 16'h8000;
    idx = 0; acc0 = n_acc; out_ready = 0;
    for (int k = 0; k < 12; k++) begin
      a_valid = (idx < 8); b_valid = (idx < 8);
      a_data = sa[idx % 8]; b_data = sb[idx % 8];
      tick();
      if (last_acc) idx++;
    end
    chk("bp_accepts", n_acc - acc0, 4);
    chk("bp_a_ready", a_ready, 0);
    chk("bp_b_ready", b_ready, 0);
    out_ready = 1; out0 = n_out;
    for (int k = 0; k < 30; k++) begin
      a_valid = (idx < 8); b_valid = (idx < 8);
      a_data = sa[idx % 8]; b_data = sb[idx % 8];
      tick();
      if (last_acc) idx++;
    end
    chk("bp_outputs", n_out - out0, 8);
    drain();

    // Join: A alone is never consumed
    acc0 = n_acc;
    a_data = 16'h1234; b_data = 16'h5678; a_valid = 1; b_valid = 0; out_ready = 1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("join_a_ready", last_a_ready, 0);
    end
    chk("join_no_accept", n_acc - acc0, 0);
    b_valid = 1;
    tick();
    chk("join_accept", last_acc, 1);
    a_valid = 0; b_valid = 0;
    drain();
    chk("join_single", n_acc - acc0, 1);

    // Reset with three samples in flight
    out0 = n_out;
    out_ready = 1; a_valid = 1; b_valid = 1;
    for (int k = 0; k < 3; k++) begin
      a_data = 16'($urandom); b_data = 16'($urandom);
      tick();
    end
    a_valid = 0; b_valid = 0; rst = 1;
    tick();
    rst = 0;
    exp_q.delete();
    chk("rst_flush_valid", m_valid, 0);
    for (int k = 0; k < 8; k++) tick();
    chk("rst_flush_no_out", n_out - out0, 0);

    // Random traffic with random backpressure
    acc0 = n_acc; out0 = n_out;
    for (int k = 0; k < 400; k++) begin
      a_valid   = ($urandom_range(0, 3) != 0);
      b_valid   = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      a_data = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
      b_data = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
      tick();
    end
    drain();
    chk("rand_count", n_out - out0, n_acc - acc0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
